// File: rtl/frame_probe_pkg.sv
// Shared types and constants for the frame probe: FSM states, frame geometry and
// the row-major shadow-frame address helper.
package frame_probe_pkg;

    localparam int         XSCREEN  = 160;
    localparam int         YSCREEN  = 120;
    localparam logic [2:0] BG       = 3'b000;
    localparam int         FB_DEPTH = 19200;
    localparam int         FB_AW    = 15;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SCAN,
        DRAIN,
        RESP
    } state_t;

    // y*160 + x built from shifts so no multiplier is needed.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_AW-1:0] yy;
        yy = {8'b0, y};
        return (yy << 7) + (yy << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/frame_probe_if.sv
// Bundle of the snooped pixel-write bus plus the probe request/response handshakes.
interface frame_probe_if;

    logic       wr_plot;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic [2:0] wr_colour;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [2:0] rsp_colour;
    logic       rsp_oob;

    modport master (
        output wr_plot, wr_x, wr_y, wr_colour,
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_colour, rsp_oob
    );

    modport slave (
        input  wr_plot, wr_x, wr_y, wr_colour,
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_colour, rsp_oob
    );

endinterface

// File: rtl/frame_probe_shadow_fb_ram.sv
// Simple dual-port 3-bit shadow frame RAM: one write port, one registered read port
// that returns the old contents when read and write hit the same address.
module shadow_fb_ram
    import frame_probe_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = FB_AW
) (
    input  logic          CLOCK_50,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [2:0]    rdata
);

    logic [2:0] mem [0:DEPTH-1];

    // NOTE: the array has no reset; the owner's CLEAR sweep initialises it, which
    // keeps it mappable onto block RAM. Non-blocking writes give read-old-data.
    always_ff @(posedge CLOCK_50) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_probe.sv
// Frame probe: snoops VGA pixel writes into a shadow frame and answers region-hit
// queries. Optional macro FRAME_PROBE_EARLY_EXIT_EN stops the scan after the first hit.
module frame_probe #(
    parameter int         XSCREEN = frame_probe_pkg::XSCREEN,
    parameter int         YSCREEN = frame_probe_pkg::YSCREEN,
    parameter int         XDIM    = 10,
    parameter int         YDIM    = 10,
    parameter logic [2:0] BG      = frame_probe_pkg::BG
) (
    input logic          CLOCK_50,
    input logic          Resetn,
    frame_probe_if.slave bus
);

    import frame_probe_pkg::*;

    localparam logic [7:0]       X_LIM    = 8'(XSCREEN);
    localparam logic [6:0]       Y_LIM    = 7'(YSCREEN);
    localparam logic [7:0]       X_MAX    = 8'(XSCREEN - XDIM);
    localparam logic [6:0]       Y_MAX    = 7'(YSCREEN - YDIM);
    localparam logic [7:0]       COL_LAST = 8'(XDIM - 1);
    localparam logic [6:0]       ROW_LAST = 7'(YDIM - 1);
    localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(FB_DEPTH - 1);

    state_t             state_q, state_d;
    logic [FB_AW-1:0]   clr_addr_q;
    logic [7:0]         base_x_q;
    logic [6:0]         base_y_q;
    logic [7:0]         col_q;
    logic [6:0]         row_q;
    logic               rd_vld_q;
    logic               hit_q;
    logic [2:0]         colour_q;
    logic               oob_q;

    logic               rd_en;
    logic               we;
    logic [FB_AW-1:0]   waddr;
    logic [2:0]         wdata;
    logic [FB_AW-1:0]   raddr;
    logic [2:0]         rd_data;
    logic               accept;
    logic               req_oob;
    logic               scan_last;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign req_oob   = (bus.req_x > X_MAX) || (bus.req_y > Y_MAX);
    assign scan_last = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign raddr     = fb_addr(base_x_q + col_q, base_y_q + row_q);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == CLR_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = req_oob ? RESP : SCAN;
                end
            end
            SCAN: begin
`ifdef FRAME_PROBE_EARLY_EXIT_EN
                if (hit_q) begin
                    state_d = DRAIN;
                end else begin
                    rd_en = 1'b1;
                    if (scan_last) begin
                        state_d = DRAIN;
                    end
                end
`else
                rd_en = 1'b1;
                if (scan_last) begin
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                // Wait until the last issued read has been folded into the hit flag.
                if (!rd_vld_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // The clear sweep owns the write port; snooped writes are dropped meanwhile.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = BG;
        if (state_q == CLEAR) begin
            we    = 1'b1;
            waddr = clr_addr_q;
        end else if (bus.wr_plot && (bus.wr_x < X_LIM) && (bus.wr_y < Y_LIM)) begin
            we    = 1'b1;
            waddr = fb_addr(bus.wr_x, bus.wr_y);
            wdata = bus.wr_colour;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            base_x_q   <= '0;
            base_y_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rd_vld_q   <= 1'b0;
            hit_q      <= 1'b0;
            colour_q   <= BG;
            oob_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_en;
            case (state_q)
                CLEAR: clr_addr_q <= clr_addr_q + 15'd1;
                IDLE: begin
                    if (accept) begin
                        base_x_q <= bus.req_x;
                        base_y_q <= bus.req_y;
                        col_q    <= '0;
                        row_q    <= '0;
                        hit_q    <= req_oob;
                        colour_q <= BG;
                        oob_q    <= req_oob;
                    end
                end
                SCAN: begin
                    if (rd_en) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 7'd1;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (rd_vld_q && (rd_data != BG) && !hit_q) begin
                hit_q    <= 1'b1;
                colour_q <= rd_data;
            end
        end
    end

    shadow_fb_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (FB_AW)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re       (rd_en),
        .raddr    (raddr),
        .rdata    (rd_data)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_hit    = hit_q;
    assign bus.rsp_colour = colour_q;
    assign bus.rsp_oob    = oob_q;

endmodule

// File: tb/tb_frame_probe.sv
// Self-checking bench for frame_probe: fixed vector table, hand-written corner
// sequences and random writes/probes against a frame-array reference model.
`timescale 1ns/1ps
module tb_frame_probe;

    localparam int XS       = 160;
    localparam int YS       = 120;
    localparam int XD       = 10;
    localparam int YD       = 10;
    localparam int SCAN_LAT = XD * YD + 2;
    localparam int CLR_CYC  = XS * YS;

    logic CLOCK_50 = 1'b0;
    logic Resetn   = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    frame_probe_if bus ();

    frame_probe #(
        .XSCREEN (XS),
        .YSCREEN (YS),
        .XDIM    (XD),
        .YDIM    (YD),
        .BG      (3'b000)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] model_fb [XS][YS];

    typedef struct {
        int         x;
        int         y;
        bit         hit;
        logic [2:0] col;
        bit         oob;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_clear();
        foreach (model_fb[i, j]) model_fb[i][j] = 3'b000;
    endtask

    task automatic write_px(input int x, input int y, input logic [2:0] c);
        bus.wr_plot   = 1'b1;
        bus.wr_x      = 8'(x);
        bus.wr_y      = 7'(y);
        bus.wr_colour = c;
        tick();
        bus.wr_plot   = 1'b0;
        if (x < XS && y < YS) model_fb[x][y] = c;
    endtask

    // Reference: row-major walk of the region in the frame array.
    task automatic model_probe(input int x, input int y, output bit hit,
                               output logic [2:0] col, output bit oob, output int lat);
        logic [2:0] c;
        oob = (x > XS - XD) || (y > YS - YD);
        hit = oob;
        col = 3'b000;
        lat = oob ? 0 : SCAN_LAT;
        if (!oob) begin
            for (int k = 0; k < XD * YD; k++) begin
                c = model_fb[x + k % XD][y + k / XD];
                if (!hit && c != 3'b000) begin
                    hit = 1'b1;
                    col = c;
`ifdef FRAME_PROBE_EARLY_EXIT_EN
                    lat = (k + 4 < SCAN_LAT) ? k + 4 : SCAN_LAT;
`endif
                end
            end
        end
    endtask

    task automatic do_probe(input int x, input int y, input int hold,
                            output bit hit, output logic [2:0] col, output bit oob,
                            output int lat, output bit stable, output bit idle_after);
        int w;
        w = 0;
        while (!bus.req_ready && w < 25000) begin
            tick();
            w++;
        end
        check($sformatf("req_ready_before_probe(%0d,%0d)", x, y), int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_x     = 8'(x);
        bus.req_y     = 7'(y);
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 400) begin
            tick();
            lat++;
        end
        hit    = bus.rsp_hit;
        col    = bus.rsp_colour;
        oob    = bus.rsp_oob;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!bus.rsp_valid || bus.req_ready || bus.rsp_hit != hit ||
                bus.rsp_colour != col || bus.rsp_oob != oob) stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        idle_after = bus.req_ready && !bus.rsp_valid;
    endtask

    task automatic run_probe(input string tag, input int x, input int y, input bit e_hit,
                             input logic [2:0] e_col, input bit e_oob);
        bit         hit, oob, stable, idle_after, m_hit, m_oob;
        logic [2:0] col, m_col;
        int         lat, m_lat;
        model_probe(x, y, m_hit, m_col, m_oob, m_lat);
        do_probe(x, y, 0, hit, col, oob, lat, stable, idle_after);
        check({tag, "_hit"}, int'(hit), int'(e_hit));
        check({tag, "_colour"}, int'(col), int'(e_col));
        check({tag, "_oob"}, int'(oob), int'(e_oob));
        check({tag, "_latency"}, lat, m_lat);
    endtask

    task automatic wait_clear(output int cnt, output bit saw_valid);
        cnt       = 0;
        saw_valid = 1'b0;
        while (!bus.req_ready && cnt < 25000) begin
            tick();
            cnt++;
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
    endtask

    initial begin
        bit         hit, oob, stable, idle_after, saw_valid, m_hit, m_oob;
        logic [2:0] col, m_col;
        int         lat, m_lat, cnt;

        bus.wr_plot   = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_colour = '0;
        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b0;
        model_clear();

        // Reset values
        repeat (3) tick();
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_hit", int'(bus.rsp_hit), 0);
        check("rst_rsp_oob", int'(bus.rsp_oob), 0);
        check("rst_rsp_colour", int'(bus.rsp_colour), 0);

        Resetn = 1'b1;
        wait_clear(cnt, saw_valid);
        check("clear_cycles", cnt, CLR_CYC);
        check("clear_no_rsp", int'(saw_valid), 0);

        run_probe("empty_origin", 0, 0, 1'b0, 3'b000, 1'b0);

        write_px(44, 63, 3'b010);
        run_probe("single_pixel", 39, 59, 1'b1, 3'b010, 1'b0);

        write_px(40, 60, 3'b100);
        write_px(45, 60, 3'b001);
        write_px(160, 0, 3'b111);
        write_px(0, 120, 3'b111);
        write_px(200, 127, 3'b101);

        vecs.push_back('{x: 40,  y: 60,  hit: 1'b1, col: 3'b100, oob: 1'b0});
        vecs.push_back('{x: 39,  y: 59,  hit: 1'b1, col: 3'b100, oob: 1'b0});
        vecs.push_back('{x: 41,  y: 60,  hit: 1'b1, col: 3'b001, oob: 1'b0});
        vecs.push_back('{x: 41,  y: 61,  hit: 1'b1, col: 3'b010, oob: 1'b0});
        vecs.push_back('{x: 45,  y: 64,  hit: 1'b0, col: 3'b000, oob: 1'b0});
        vecs.push_back('{x: 35,  y: 54,  hit: 1'b1, col: 3'b100, oob: 1'b0});
        vecs.push_back('{x: 45,  y: 54,  hit: 1'b1, col: 3'b001, oob: 1'b0});
        vecs.push_back('{x: 0,   y: 0,   hit: 1'b0, col: 3'b000, oob: 1'b0});
        vecs.push_back('{x: 150, y: 110, hit: 1'b0, col: 3'b000, oob: 1'b0});
        vecs.push_back('{x: 151, y: 59,  hit: 1'b1, col: 3'b000, oob: 1'b1});
        vecs.push_back('{x: 150, y: 111, hit: 1'b1, col: 3'b000, oob: 1'b1});
        vecs.push_back('{x: 255, y: 0,   hit: 1'b1, col: 3'b000, oob: 1'b1});
        foreach (vecs[i]) begin
            run_probe($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                      vecs[i].hit, vecs[i].col, vecs[i].oob);
        end

        // Back-pressure on the response channel
        do_probe(40, 60, 20, hit, col, oob, lat, stable, idle_after);
        check("hold_hit", int'(hit), 1);
        check("hold_colour", int'(col), 4);
        check("hold_stable", int'(stable), 1);
        check("hold_idle_after_ack", int'(idle_after), 1);

        // Writes during SCAN: an already-read pixel is ignored, a later one is seen
        begin
            int w;
            w = 0;
            while (!bus.req_ready && w < 25000) begin
                tick();
                w++;
            end
            bus.req_valid = 1'b1;
            bus.req_x     = 8'd100;
            bus.req_y     = 7'd50;
            tick();
            bus.req_valid = 1'b0;
            lat = 0;
            repeat (49) begin
                tick();
                lat++;
            end
            write_px(100, 50, 3'b111);
            lat++;
            write_px(109, 59, 3'b011);
            lat++;
            while (!bus.rsp_valid && lat < 400) begin
                tick();
                lat++;
            end
            check("snoop_scan_latency", lat, SCAN_LAT);
            check("snoop_scan_hit", int'(bus.rsp_hit), 1);
            check("snoop_scan_colour", int'(bus.rsp_colour), 3);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
        run_probe("snoop_reprobe", 100, 50, 1'b1, 3'b111, 1'b0);

        // Hit on the first pixel of the region
        write_px(10, 10, 3'b110);
        model_probe(10, 10, m_hit, m_col, m_oob, m_lat);
        do_probe(10, 10, 0, hit, col, oob, lat, stable, idle_after);
        check("first_px_colour", int'(col), 6);
        check("first_px_latency", lat, m_lat);
`ifdef FRAME_PROBE_EARLY_EXIT_EN
        check("early_exit_within_4", int'(lat <= 4), 1);
`endif

        // Reset in the middle of a scan
        begin
            int w;
            w = 0;
            while (!bus.req_ready && w < 25000) begin
                tick();
                w++;
            end
            bus.req_valid = 1'b1;
            bus.req_x     = 8'd120;
            bus.req_y     = 7'd100;
            tick();
            bus.req_valid = 1'b0;
            saw_valid = 1'b0;
            repeat (30) begin
                tick();
                if (bus.rsp_valid) saw_valid = 1'b1;
            end
            Resetn = 1'b0;
            repeat (2) tick();
            check("midscan_rst_ready", int'(bus.req_ready), 0);
            check("midscan_rst_valid", int'(bus.rsp_valid | saw_valid), 0);
            Resetn = 1'b1;
            wait_clear(cnt, saw_valid);
            check("midscan_clear_cycles", cnt, CLR_CYC);
            check("midscan_no_rsp", int'(saw_valid), 0);
            model_clear();
        end
        run_probe("after_reclear", 40, 60, 1'b0, 3'b000, 1'b0);

        // Random writes and probes against the reference frame
        for (int p = 0; p < 30; p++) begin
            int px, py;
            for (int wi = 0; wi < 8; wi++) begin
                write_px(int'($urandom_range(0, 169)), int'($urandom_range(0, 124)),
                         3'($urandom_range(0, 7)));
            end
            px = int'($urandom_range(0, 155));
            py = int'($urandom_range(0, 115));
            model_probe(px, py, m_hit, m_col, m_oob, m_lat);
            run_probe($sformatf("rand%0d(%0d,%0d)", p, px, py), px, py, m_hit, m_col, m_oob);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_probe.md
FRAME_PROBE -- requirements
Module: frame_probe

Interface
REQ-001 Parameters SHALL be: XSCREEN 160, frame width in pixels; YSCREEN 120, frame height; XDIM 10, probe region width; YDIM 10, probe region height; BG 3'b000, background colour.
REQ-002 CLOCK_50  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 Resetn  in  1  reset, synchronous, active-low.
REQ-004 wr_plot  in  1  snooped pixel write strobe, identical to the write strobe driven to vga_adapter.
REQ-005 wr_x  in  8  snooped write column.
REQ-006 wr_y  in  7  snooped write row.
REQ-007 wr_colour  in  3  snooped write colour.
REQ-008 req_valid  in  1  probe request valid.
REQ-009 req_ready  out  1  probe accepts a request.
REQ-010 req_x  in  8  region top-left column.
REQ-011 req_y  in  7  region top-left row.
REQ-012 rsp_valid  out  1  result valid.
REQ-013 rsp_ready  in  1  result consumed.
REQ-014 rsp_hit  out  1  region contains a non-BG pixel, or the region is out of bounds.
REQ-015 rsp_colour  out  3  first non-BG colour in row-major order; BG if none.
REQ-016 rsp_oob  out  1  region exceeds the frame.

Function
REQ-017 Block SHALL hold a shadow frame of XSCREEN*YSCREEN 3-bit entries at address y*160+x (15 bits, computed as (y<<7)+(y<<5)+x).
REQ-018 A snooped write with wr_plot=1, wr_x<XSCREEN and wr_y<YSCREEN SHALL update the entry on the same edge; out-of-range writes SHALL be ignored.
REQ-019 Read port SHALL have 1-cycle latency; a read and a write to the same address in one cycle SHALL return the old data.
REQ-020 FSM states SHALL be CLEAR, IDLE, SCAN, DRAIN and RESP.
REQ-021 CLEAR: write BG to addresses 0..19199, one per cycle; snooped writes ignored; req_ready=0; then go to IDLE.
REQ-022 IDLE: req_ready=1; a handshake (req_valid & req_ready) SHALL latch req_x/req_y.
REQ-023 Out of bounds SHALL be req_x>XSCREEN-XDIM or req_y>YSCREEN-YDIM.
REQ-024 If out of bounds: no reads; go directly to RESP with rsp_oob=1, rsp_hit=1, rsp_colour=BG.
REQ-025 SCAN: issue one read per cycle over the region, column counter inner and row counter outer, for XDIM*YDIM cycles; then go to DRAIN.
REQ-026 Each returned word that is non-BG while no hit is yet recorded SHALL set the hit flag and capture its colour.
REQ-027 DRAIN: consume the final read data, then go to RESP.
REQ-028 An in-bounds response SHALL assert rsp_valid exactly XDIM*YDIM+2 cycles after the accept edge (102 with defaults).
REQ-029 RESP: rsp_valid=1 with outputs stable until rsp_valid & rsp_ready; return to IDLE on the next edge.
REQ-030 req_ready SHALL be 0 in every state except IDLE.
REQ-031 Snooped writes SHALL continue during SCAN; a pixel already read SHALL NOT be re-evaluated.

Reset
REQ-032 Resetn=0 SHALL, from any state, force CLEAR with the clear address at 0 and all counters at 0.
REQ-033 Output reset values SHALL be req_ready=0, rsp_valid=0, rsp_hit=0, rsp_oob=0, rsp_colour=BG.
REQ-034 A reset during SCAN or RESP SHALL discard the pending result with no response issued.

Configuration
REQ-035 Macro FRAME_PROBE_EARLY_EXIT_EN, when defined, SHALL end SCAN on the cycle after the first hit returns: go to DRAIN and then RESP, so latency is variable.
REQ-036 Without FRAME_PROBE_EARLY_EXIT_EN, the full region SHALL always be scanned at the fixed latency of REQ-028.

Structure
REQ-037 Package frame_probe_pkg SHALL hold the state enum, the XSCREEN, YSCREEN and BG constants, and FB_DEPTH=19200.
REQ-038 Sub-module shadow_fb_ram SHALL implement the simple dual-port 3-bit x 19200 RAM, with 1 write port and 1 read port.

Verification
REQ-039 Reset release -> req_ready=0 for 19200 cycles, then 1; a probe at (0,0) returns rsp_hit=0, rsp_colour=000.
REQ-040 Write (44,63)=3'b010, then probe (39,59) -> rsp_hit=1, rsp_colour=010, rsp_valid 102 cycles after accept.
REQ-041 Probe (151,59) -> rsp_oob=1, rsp_hit=1 on the edge after accept, no reads issued.
REQ-042 Writes (40,60)=100 and (45,60)=001, then probe (40,60) -> rsp_colour=100 (row-major first).
REQ-043 Hold rsp_ready=0 for 20 cycles -> outputs stable and req_ready=0; rsp_ready=1 -> IDLE next edge.
REQ-044 Resetn=0 mid-SCAN -> rsp_valid never asserts, CLEAR re-runs; with FRAME_PROBE_EARLY_EXIT_EN, a hit at the region's first pixel gives rsp_valid within 4 cycles of accept.
